// File: rtl/fib_step_sequencer_pkg.sv
// Shared types for the Fibonacci step sequencer: FSM state encoding and default generator width.
package fib_step_sequencer_pkg;

  localparam int FIB_W = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_SAMPLE = 3'd2,
    S_WAIT   = 3'd3,
    S_STEP   = 3'd4
  } state_t;

endpackage

// File: rtl/fib_step_sequencer_fifo.sv
// First-word fall-through FIFO holding {wrap, fn} samples; accepts push while full when a pop lands.
module fib_step_sequencer_fifo #(
  parameter int W     = 5,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO may still take a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fib_step_sequencer.sv
// Drives a 4-bit Fibonacci generator step by step, captures each term with a wrap flag into a FIFO
// and hands the samples downstream over valid/ready, holding the generator while the FIFO is full.
module fib_step_sequencer
  import fib_step_sequencer_pkg::*;
#(
  parameter int W        = FIB_W,
  parameter int DEPTH    = 4,
  parameter int INTERVAL = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic [W-1:0]           fib_fn,
  output logic                   fib_init,
  output logic                   fib_en,
  output logic [W-1:0]           out_data,
  output logic                   out_wrap,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy
);

  localparam int CNT_W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((INTERVAL > 0) ? INTERVAL - 1 : 0);

  state_t           state;
  logic [W-1:0]     prev;
  logic [CNT_W-1:0] wcnt;
  logic             full;
  logic             empty;
  logic             pop;
  logic             push;
  logic             wrap;
  logic [W:0]       head;

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  // stop beats a push landing in the same cycle.
  assign push      = (state == S_SAMPLE) && !stop && (!full || pop);
  assign wrap      = (fib_fn < prev);
  assign out_wrap  = head[W];
  assign out_data  = head[W-1:0];

  fib_step_sequencer_fifo #(
    .W     (W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({wrap, fib_fn}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // fib_init/fib_en are set on entry to INIT/STEP so they are clean registered pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      fib_init <= 1'b0;
      fib_en   <= 1'b0;
      busy     <= 1'b0;
      prev     <= '0;
      wcnt     <= '0;
    end else begin
      fib_init <= 1'b0;
      fib_en   <= 1'b0;
      if (state != S_IDLE && stop) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !stop) begin
              state    <= S_INIT;
              fib_init <= 1'b1;
              fib_en   <= 1'b1;
              busy     <= 1'b1;
            end
          end
          S_INIT: begin
            prev  <= '0;
            state <= S_SAMPLE;
          end
          S_SAMPLE: begin
            if (push) begin
              prev <= fib_fn;
              if (INTERVAL > 0) begin
                state <= S_WAIT;
                wcnt  <= '0;
              end else begin
                state  <= S_STEP;
                fib_en <= 1'b1;
              end
            end
          end
          S_WAIT: begin
            if (wcnt == WAIT_LAST) begin
              state  <= S_STEP;
              fib_en <= 1'b1;
            end else begin
              wcnt <= wcnt + CNT_W'(1);
            end
          end
          S_STEP:  state <= S_SAMPLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fib_step_sequencer.sv
// Bench for fib_step_sequencer: two configurations, each with a behavioural Fibonacci generator,
// checked every cycle against a transaction-level model of the push schedule and FIFO contents.
module tb_fib_step_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start [2];
  logic stop  [2];
  logic ready [2];

  // Instance A: W=4, DEPTH=4, INTERVAL=2
  logic [3:0] a_fn, a_data;
  logic       a_init, a_en, a_wrap, a_valid, a_busy;
  logic [2:0] a_count;
  // Instance B: W=4, DEPTH=2, INTERVAL=0
  logic [3:0] b_fn, b_data;
  logic       b_init, b_en, b_wrap, b_valid, b_busy;
  logic [1:0] b_count;

  fib_step_sequencer #(.W(4), .DEPTH(4), .INTERVAL(2)) dut_a (
    .clk(clk), .rst(rst), .start(start[0]), .stop(stop[0]), .fib_fn(a_fn),
    .fib_init(a_init), .fib_en(a_en), .out_data(a_data), .out_wrap(a_wrap),
    .out_valid(a_valid), .out_ready(ready[0]), .count(a_count), .busy(a_busy)
  );

  fib_step_sequencer #(.W(4), .DEPTH(2), .INTERVAL(0)) dut_b (
    .clk(clk), .rst(rst), .start(start[1]), .stop(stop[1]), .fib_fn(b_fn),
    .fib_init(b_init), .fib_en(b_en), .out_data(b_data), .out_wrap(b_wrap),
    .out_valid(b_valid), .out_ready(ready[1]), .count(b_count), .busy(b_busy)
  );

  // Fibonacci generators: fn = R2, sync init to (0,1), advance on en.
  logic [3:0] ga1 = 4'd0, ga2 = 4'd0, gb1 = 4'd0, gb2 = 4'd0;
  always @(posedge clk) begin
    if (a_init) begin ga1 <= 4'd0; ga2 <= 4'd1; end
    else if (a_en) begin ga1 <= ga2; ga2 <= ga1 + ga2; end
    if (b_init) begin gb1 <= 4'd0; gb2 <= 4'd1; end
    else if (b_en) begin gb1 <= gb2; gb2 <= gb1 + gb2; end
  end
  assign a_fn = ga2;
  assign b_fn = gb2;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference model: a run pushes its first term 2 cycles after start, then one term every
  // INTERVAL+2 cycles; a due push that finds the queue full (and no pop) slips by a cycle.
  int         depth [2] = '{4, 2};
  int         ival  [2] = '{2, 0};
  int         cyc = 0;
  bit         run     [2];
  int         due     [2];
  int         en_at   [2];
  int         init_at [2];
  logic [3:0] fa [2], fb [2], prv [2];
  logic [4:0] ring [2][8];
  int         hd [2], cnt [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      run[i] = 0; due[i] = -1; en_at[i] = -1; init_at[i] = -1;
      hd[i] = 0; cnt[i] = 0; fa[i] = 0; fb[i] = 1; prv[i] = 0;
    end
  endtask

  task automatic model_step(input int i);
    bit         pop, push;
    logic [4:0] e;
    logic [3:0] nxt;
    pop  = (cnt[i] > 0) && ready[i];
    push = 0;
    e    = '0;
    if (run[i]) begin
      if (stop[i]) run[i] = 0;
      else if (cyc == due[i]) begin
        if (cnt[i] < depth[i] || pop) begin
          push  = 1;
          e     = {fb[i] < prv[i], fb[i]};
          prv[i] = fb[i];
          nxt   = fa[i] + fb[i];
          fa[i] = fb[i];
          fb[i] = nxt;
          due[i]   = cyc + ival[i] + 2;
          en_at[i] = cyc + ival[i] + 1;
        end else begin
          due[i] = cyc + 1;
        end
      end
    end else if (start[i] && !stop[i]) begin
      run[i] = 1; init_at[i] = cyc + 1; en_at[i] = cyc + 1; due[i] = cyc + 2;
      fa[i] = 0; fb[i] = 1; prv[i] = 0;
    end
    if (pop) begin hd[i] = (hd[i] + 1) % 8; cnt[i]--; end
    if (push) begin ring[i][(hd[i] + cnt[i]) % 8] = e; cnt[i]++; end
  endtask

  task automatic check_inst(input int i, input logic valid, input logic [3:0] data, input logic wrap,
                            input int count, input logic busy, input logic init, input logic en);
    check($sformatf("i%0d.valid", i), int'(valid), int'(cnt[i] > 0));
    check($sformatf("i%0d.count", i), count, cnt[i]);
    check($sformatf("i%0d.busy", i), int'(busy), int'(run[i]));
    check($sformatf("i%0d.init", i), int'(init), int'(run[i] && cyc == init_at[i]));
    check($sformatf("i%0d.en", i), int'(en), int'(run[i] && cyc == en_at[i]));
    if (cnt[i] > 0) begin
      check($sformatf("i%0d.data", i), int'(data), int'(ring[i][hd[i]][3:0]));
      check($sformatf("i%0d.wrap", i), int'(wrap), int'(ring[i][hd[i]][4]));
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".a_init"}, int'(a_init), 0);   check({tag, ".a_en"}, int'(a_en), 0);
    check({tag, ".a_valid"}, int'(a_valid), 0); check({tag, ".a_data"}, int'(a_data), 0);
    check({tag, ".a_wrap"}, int'(a_wrap), 0);   check({tag, ".a_count"}, int'(a_count), 0);
    check({tag, ".a_busy"}, int'(a_busy), 0);
    check({tag, ".b_valid"}, int'(b_valid), 0); check({tag, ".b_data"}, int'(b_data), 0);
    check({tag, ".b_count"}, int'(b_count), 0); check({tag, ".b_busy"}, int'(b_busy), 0);
  endtask

  // Expected pop stream of the first run with a free-flowing consumer.
  int tbl  [10] = '{1, 1, 2, 3, 5, 8, 13, 5, 2, 7};
  int wtbl [10] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0};
  bit tbl_on = 0;
  int tk = 0;

  task automatic run_cycle();
    if (tbl_on && a_valid && ready[0]) begin
      if (tk < 10) begin
        check("seq.data", int'(a_data), tbl[tk]);
        check("seq.wrap", int'(a_wrap), wtbl[tk]);
      end
      tk++;
    end
    model_step(0);
    model_step(1);
    cyc++;
    @(negedge clk);
    check_inst(0, a_valid, a_data, a_wrap, int'(a_count), a_busy, a_init, a_en);
    check_inst(1, b_valid, b_data, b_wrap, int'(b_count), b_busy, b_init, b_en);
  endtask

  task automatic pulse(input int i, input bit is_start);
    if (is_start) start[i] = 1'b1; else stop[i] = 1'b1;
    run_cycle();
    start[i] = 1'b0;
    stop[i]  = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin start[i] = 0; stop[i] = 0; ready[i] = 0; end
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;

    // Free-flowing consumer: first ten terms including the two modular wraps.
    ready[0] = 1'b1;
    pulse(0, 1);
    tbl_on = 1;
    repeat (45) run_cycle();
    tbl_on = 0;
    check("seq.seen", int'(tk >= 10), 1);
    pulse(0, 0);

    // Stalled consumer: FIFO fills and the generator is held, then drains without a gap.
    ready[0] = 1'b0;
    pulse(0, 1);
    repeat (30) run_cycle();
    check("full.count", int'(a_count), 4);
    check("full.en", int'(a_en), 0);
    ready[0] = 1'b1;
    repeat (30) run_cycle();
    pulse(0, 0);

    // Stop three cycles after the first push; queued entries survive, restart begins at 1.
    ready[0] = 1'b0;
    pulse(0, 1);
    repeat (5) run_cycle();
    pulse(0, 0);
    check("stop.busy", int'(a_busy), 0);
    repeat (8) run_cycle();
    ready[0] = 1'b1;
    repeat (4) run_cycle();
    pulse(0, 1);
    repeat (12) run_cycle();
    pulse(0, 0);

    // Asynchronous reset while waiting with two entries queued.
    repeat (4) run_cycle();
    ready[0] = 1'b0;
    pulse(0, 1);
    repeat (6) run_cycle();
    check("wait.count", int'(a_count), 2);
    #2 rst = 1'b0;
    #1 check_zero("midreset");
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    ready[0] = 1'b1;
    pulse(0, 1);
    repeat (15) run_cycle();
    pulse(0, 0);

    // DEPTH=2, INTERVAL=0 with a consumer toggling every cycle.
    ready[1] = 1'b0;
    pulse(1, 1);
    for (int k = 0; k < 40; k++) begin
      ready[1] = ~ready[1];
      run_cycle();
      check("b.maxcount", int'(b_count <= 2'd2), 1);
    end
    pulse(1, 0);

    // Randomised control and backpressure on both instances.
    for (int k = 0; k < 800; k++) begin
      for (int i = 0; i < 2; i++) begin
        start[i] = ($urandom_range(0, 11) == 0);
        stop[i]  = ($urandom_range(0, 39) == 0);
        ready[i] = ($urandom_range(0, 2) != 0);
      end
      run_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
